// File: rtl/refwin_pkg.sv
// refwin_pkg: shared defaults, FSM state type and window size for the refwin reader
package refwin_pkg;
    localparam int W_SIZE_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int WIN_PIX = W_SIZE_DEF * W_SIZE_DEF;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    function automatic int win_pix(input int w);
        return w * w;
    endfunction
endpackage

// File: rtl/refwin_skid.sv
// refwin_skid: 2-entry output skid buffer with valid/ready handshake
module refwin_skid import refwin_pkg::*; #(
    parameter int W = DATA_W_DEF + 1
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic wptr, rptr, pop;
    assign valid = count != 2'd0;
    assign pop = valid && ready;
    assign dout = valid ? mem[rptr] : '0;
    always_ff @(posedge pclk)
        if (push) mem[wptr] <= din;
    always_ff @(posedge pclk) begin
        if (rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/refwin_reader.sv
// refwin_reader: double-buffered window reader streaming W_SIZE*W_SIZE samples per filled bank
// REFWIN_RD_OVERRUN_EN enables the sticky overrun detector.
module refwin_reader import refwin_pkg::*; #(
    parameter int W_SIZE = W_SIZE_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                                 pclk,
    input  logic                                 rst,
    input  logic                                 win_wr,
    output logic                                 wr_bank,
    output logic [$clog2(2*W_SIZE*W_SIZE)-1:0]   rd_addr,
    output logic                                 rd_en,
    input  logic [DATA_W-1:0]                    rd_data,
    output logic [DATA_W-1:0]                    pix_out,
    output logic                                 pix_valid,
    input  logic                                 pix_ready,
    output logic                                 pix_last,
    output logic                                 win_done,
    output logic                                 overrun
);
    localparam int NPIX = win_pix(W_SIZE);
    localparam int IW = $clog2(NPIX);
    state_t state;
    logic [IW-1:0] wcnt, ridx;
    logic [1:0] full, clr, set, occ;
    logic rbank, fly, fly_last, wr_done, fin;
    logic [DATA_W:0] sk_out;
    assign wr_done = win_wr && wcnt == IW'(NPIX - 1);
    assign fin = state == DRAIN && pix_valid && pix_ready && pix_last;
    assign clr = fin ? (rbank ? 2'b10 : 2'b01) : 2'b00;
    assign set = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
    // issue only if the sample lands in a slot that is free once it returns
    assign rd_en = state == READ && ({1'b0, occ} + {2'b0, fly} - {2'b0, pix_valid && pix_ready}) < 3'd2;
    assign rd_addr = {rbank, ridx};
    refwin_skid #(.W(DATA_W + 1)) u_skid (
        .pclk  (pclk),
        .rst   (rst),
        .push  (fly),
        .din   ({fly_last, rd_data}),
        .ready (pix_ready),
        .valid (pix_valid),
        .dout  (sk_out),
        .count (occ)
    );
    assign {pix_last, pix_out} = sk_out;
    always_ff @(posedge pclk) begin
        if (rst) begin
            wcnt <= '0;
            wr_bank <= 1'b0;
            full <= 2'b00;
        end else begin
            if (win_wr) wcnt <= wr_done ? '0 : wcnt + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
            full <= (full & ~clr) | set;
        end
    end
`ifdef REFWIN_RD_OVERRUN_EN
    // a bank finishing in the same cycle the reader releases the other is not an overrun
    always_ff @(posedge pclk) begin
        if (rst) overrun <= 1'b0;
        else if (wr_done && full[~wr_bank] && !clr[~wr_bank]) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= IDLE;
            rbank <= 1'b0;
            ridx <= '0;
            fly <= 1'b0;
            fly_last <= 1'b0;
            win_done <= 1'b0;
        end else begin
            fly <= rd_en;
            fly_last <= rd_en && ridx == IW'(NPIX - 1);
            win_done <= fin;
            case (state)
                IDLE: if (full[~wr_bank]) begin
                    state <= READ;
                    rbank <= ~wr_bank;
                    ridx <= '0;
                end
                READ: if (rd_en) begin
                    ridx <= ridx + 1'b1;
                    if (ridx == IW'(NPIX - 1)) state <= DRAIN;
                end
                DRAIN: if (fin) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_refwin_reader.sv
// tb_refwin_reader: directed checks of the refwin reader at W_SIZE 8 and 4
module tb_refwin_reader;
    localparam int N = 64;
    localparam int N4 = 16;
`ifdef REFWIN_RD_OVERRUN_EN
    localparam logic EXP_OV = 1'b1;
`else
    localparam logic EXP_OV = 1'b0;
`endif
    logic pclk = 1'b0, rst = 1'b1, win_wr = 1'b0, pix_ready = 1'b0;
    logic wr_bank, rd_en, pix_valid, pix_last, win_done, overrun;
    logic [6:0] rd_addr;
    logic [7:0] rd_data = 8'd0, pix_out;
    logic wr_bank4, rd_en4, pix_valid4, pix_last4, win_done4, overrun4;
    logic [4:0] rd_addr4;
    logic [7:0] rd_data4 = 8'd0, pix_out4;
    int tests = 0, fails = 0, cyc = 0;
    int acc_data[$], acc_last[$], acc_cyc[$], iss_addr[$], iss_cyc[$], done_cyc[$];
    int acc4_data[$], acc4_last[$], iss4_addr[$], done4_cyc[$];

    refwin_reader dut (
        .pclk(pclk), .rst(rst), .win_wr(win_wr), .wr_bank(wr_bank), .rd_addr(rd_addr),
        .rd_en(rd_en), .rd_data(rd_data), .pix_out(pix_out), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_last(pix_last), .win_done(win_done), .overrun(overrun)
    );
    refwin_reader #(.W_SIZE(4), .DATA_W(8)) u4 (
        .pclk(pclk), .rst(rst), .win_wr(win_wr), .wr_bank(wr_bank4), .rd_addr(rd_addr4),
        .rd_en(rd_en4), .rd_data(rd_data4), .pix_out(pix_out4), .pix_valid(pix_valid4),
        .pix_ready(pix_ready), .pix_last(pix_last4), .win_done(win_done4), .overrun(overrun4)
    );

    always #5 pclk = ~pclk;

    function automatic int mdat(input int a);
        return (a * 5 + 3) % 256;
    endfunction

    always @(posedge pclk) if (rd_en) rd_data <= 8'(mdat(int'(rd_addr)));
    always @(posedge pclk) if (rd_en4) rd_data4 <= 8'(mdat(int'(rd_addr4)));

    task automatic tick(input logic r, input logic rdy, input logic wr);
        @(negedge pclk);
        rst = r;
        pix_ready = rdy;
        win_wr = wr;
        #1;
        cyc++;
        if (rd_en) begin iss_addr.push_back(int'(rd_addr)); iss_cyc.push_back(cyc); end
        if (pix_valid && pix_ready) begin
            acc_data.push_back(int'(pix_out));
            acc_last.push_back(int'(pix_last));
            acc_cyc.push_back(cyc);
        end
        if (win_done) done_cyc.push_back(cyc);
        if (rd_en4) iss4_addr.push_back(int'(rd_addr4));
        if (pix_valid4 && pix_ready) begin
            acc4_data.push_back(int'(pix_out4));
            acc4_last.push_back(int'(pix_last4));
        end
        if (win_done4) done4_cyc.push_back(cyc);
    endtask

    task automatic clear_q;
        acc_data.delete(); acc_last.delete(); acc_cyc.delete();
        iss_addr.delete(); iss_cyc.delete(); done_cyc.delete();
        acc4_data.delete(); acc4_last.delete(); iss4_addr.delete(); done4_cyc.delete();
    endtask

    task automatic test_reset;
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tests++;
        if ({pix_valid, pix_last, win_done, rd_en, overrun, wr_bank} !== 6'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b want 000000", {pix_valid, pix_last, win_done, rd_en, overrun, wr_bank});
        end
        tests++;
        if (rd_addr !== 7'd0 || pix_out !== 8'd0) begin
            fails++;
            $display("FAIL reset_data: rd_addr %0d pix_out %0d want 0 0", rd_addr, pix_out);
        end
        tests++;
        if ({pix_valid4, pix_last4, win_done4, rd_en4, overrun4, wr_bank4, rd_addr4, pix_out4} !== 19'd0) begin
            fails++;
            $display("FAIL reset_w4: got %h want 0", {pix_valid4, pix_last4, win_done4, rd_en4, overrun4, wr_bank4, rd_addr4, pix_out4});
        end
    endtask

    task automatic test_basic;
        int k = 0;
        clear_q();
        repeat (N) tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (wr_bank !== 1'b1) begin fails++; $display("FAIL basic_wr_bank: got %b want 1", wr_bank); end
        while (done_cyc.size() == 0 && k < 300) begin tick(1'b0, 1'b1, 1'b0); k++; end
        repeat (4) tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (iss_addr.size() != N || acc_data.size() != N || done_cyc.size() != 1) begin
            fails++;
            $display("FAIL basic_counts: issued %0d accepted %0d done %0d want %0d %0d 1", iss_addr.size(), acc_data.size(), done_cyc.size(), N, N);
        end
        if (iss_cyc.size() > 0 && acc_cyc.size() > 0) begin
            tests++;
            if (acc_cyc[0] != iss_cyc[0] + 2) begin fails++; $display("FAIL basic_latency: got %0d want 2", acc_cyc[0] - iss_cyc[0]); end
        end
        for (int i = 0; i < iss_addr.size() && i < N; i++) begin
            tests++;
            if (iss_addr[i] != i || iss_cyc[i] != iss_cyc[0] + i) begin
                fails++;
                $display("FAIL basic_addr[%0d]: addr %0d gap %0d want %0d %0d", i, iss_addr[i], iss_cyc[i] - iss_cyc[0], i, i);
            end
        end
        for (int i = 0; i < acc_data.size() && i < N; i++) begin
            tests++;
            if (acc_data[i] != mdat(i) || acc_last[i] != int'(i == N - 1) || acc_cyc[i] != acc_cyc[0] + i) begin
                fails++;
                $display("FAIL basic_pix[%0d]: data %0d last %0d gap %0d want %0d %0d %0d", i, acc_data[i], acc_last[i], acc_cyc[i] - acc_cyc[0], mdat(i), int'(i == N - 1), i);
            end
        end
        if (done_cyc.size() > 0 && acc_cyc.size() == N) begin
            tests++;
            if (done_cyc[0] != acc_cyc[N-1] + 1) begin fails++; $display("FAIL basic_done_time: got %0d want 1", done_cyc[0] - acc_cyc[N-1]); end
        end
        tests++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL basic_overrun: got %b want 0", overrun); end
    endtask

    task automatic test_random_ready;
        int k = 0, bad = 0, stalls = 0;
        logic hold = 1'b0, hl = 1'b0;
        logic [7:0] hp = 8'd0;
        clear_q();
        repeat (N) tick(1'b0, 1'b0, 1'b1);
        while (done_cyc.size() == 0 && k < 3000) begin
            tick(1'b0, $urandom_range(99) < 30, 1'b0);
            if (hold && (!pix_valid || pix_out !== hp || pix_last !== hl)) bad++;
            hold = pix_valid && !pix_ready;
            hp = pix_out;
            hl = pix_last;
            if (hold) stalls++;
            k++;
        end
        tests++;
        if (bad != 0 || stalls == 0) begin fails++; $display("FAIL rand_stall_stable: %0d changes over %0d stalls, want 0 changes", bad, stalls); end
        tests++;
        if (acc_data.size() != N || done_cyc.size() != 1) begin
            fails++;
            $display("FAIL rand_count: accepted %0d done %0d want %0d 1", acc_data.size(), done_cyc.size(), N);
        end
        for (int i = 0; i < acc_data.size() && i < N; i++) begin
            tests++;
            if (acc_data[i] != mdat(N + i) || acc_last[i] != int'(i == N - 1)) begin
                fails++;
                $display("FAIL rand_pix[%0d]: data %0d last %0d want %0d %0d", i, acc_data[i], acc_last[i], mdat(N + i), int'(i == N - 1));
            end
        end
    endtask

    task automatic test_overrun;
        int k = 0;
        clear_q();
        repeat (2 * N) tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tests++;
        if (overrun !== EXP_OV || wr_bank !== 1'b0) begin
            fails++;
            $display("FAIL ovr_flag: overrun %b wr_bank %b want %b 0", overrun, wr_bank, EXP_OV);
        end
        while (done_cyc.size() < 2 && k < 600) begin tick(1'b0, 1'b1, 1'b0); k++; end
        tests++;
        if (acc_data.size() != 2 * N || done_cyc.size() != 2) begin
            fails++;
            $display("FAIL ovr_drain: accepted %0d done %0d want %0d 2", acc_data.size(), done_cyc.size(), 2 * N);
        end else begin
            tests++;
            if (acc_data[0] != mdat(0) || acc_data[N] != mdat(N) || acc_last[N-1] != 1) begin
                fails++;
                $display("FAIL ovr_order: first %0d second %0d want %0d %0d", acc_data[0], acc_data[N], mdat(0), mdat(N));
            end
        end
        tests++;
        if (overrun !== EXP_OV) begin fails++; $display("FAIL ovr_sticky: got %b want %b", overrun, EXP_OV); end
    endtask

    task automatic test_back_to_back;
        int k = 0;
        logic lastacc = 1'b0;
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        clear_q();
        repeat (N) tick(1'b0, 1'b0, 1'b1);
        repeat (N - 1) tick(1'b0, 1'b0, 1'b1);
        while (!lastacc && k < 500) begin
            tick(1'b0, 1'b1, 1'b0);
            lastacc = pix_valid && pix_ready && pix_last;
            k++;
        end
        tests++;
        if (!lastacc) begin fails++; $display("FAIL b2b_last: no last sample within %0d cycles", k); end
        tick(1'b0, 1'b1, 1'b1);
        tests++;
        if (win_done !== 1'b1) begin fails++; $display("FAIL b2b_done: got %b want 1", win_done); end
        tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (wr_bank !== 1'b0 || rd_en !== 1'b0) begin fails++; $display("FAIL b2b_idle: wr_bank %b rd_en %b want 0 0", wr_bank, rd_en); end
        tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (rd_en !== 1'b1 || rd_addr !== 7'd64 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL b2b_reread: rd_en %b rd_addr %0d overrun %b want 1 64 0", rd_en, rd_addr, overrun);
        end
    endtask

    task automatic test_reset_mid;
        int k = 0;
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        clear_q();
        repeat (N) tick(1'b0, 1'b1, 1'b1);
        while (acc_data.size() < 30 && k < 200) begin tick(1'b0, 1'b1, 1'b0); k++; end
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tests++;
        if ({pix_valid, rd_en, wr_bank, pix_last} !== 4'b0 || rd_addr !== 7'd0 || pix_out !== 8'd0) begin
            fails++;
            $display("FAIL rstmid_state: valid %b rd_en %b wr_bank %b addr %0d pix %0d want all 0", pix_valid, rd_en, wr_bank, rd_addr, pix_out);
        end
        clear_q();
        repeat (20) tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (iss_addr.size() != 0 || acc_data.size() != 0) begin
            fails++;
            $display("FAIL rstmid_quiet: issued %0d accepted %0d want 0 0", iss_addr.size(), acc_data.size());
        end
        repeat (N) tick(1'b0, 1'b1, 1'b1);
        k = 0;
        while (iss_addr.size() == 0 && k < 20) begin tick(1'b0, 1'b1, 1'b0); k++; end
        tests++;
        if (iss_addr.size() == 0) begin fails++; $display("FAIL rstmid_resume: no rd_en within %0d cycles", k); end
        else if (iss_addr[0] != 0) begin fails++; $display("FAIL rstmid_resume: first addr %0d want 0", iss_addr[0]); end
    endtask

    task automatic test_small_window;
        repeat (2) tick(1'b1, 1'b0, 1'b0);
        clear_q();
        repeat (2 * N4) tick(1'b0, 1'b1, 1'b1);
        repeat (60) tick(1'b0, 1'b1, 1'b0);
        tests++;
        if (iss4_addr.size() != 2 * N4 || acc4_data.size() != 2 * N4 || done4_cyc.size() != 2) begin
            fails++;
            $display("FAIL w4_counts: issued %0d accepted %0d done %0d want 32 32 2", iss4_addr.size(), acc4_data.size(), done4_cyc.size());
        end
        for (int i = 0; i < iss4_addr.size() && i < 2 * N4; i++) begin
            tests++;
            if (iss4_addr[i] != i) begin fails++; $display("FAIL w4_addr[%0d]: got %0d want %0d", i, iss4_addr[i], i); end
        end
        for (int i = 0; i < acc4_data.size() && i < 2 * N4; i++) begin
            tests++;
            if (acc4_data[i] != mdat(i) || acc4_last[i] != int'(i % N4 == N4 - 1)) begin
                fails++;
                $display("FAIL w4_pix[%0d]: data %0d last %0d want %0d %0d", i, acc4_data[i], acc4_last[i], mdat(i), int'(i % N4 == N4 - 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_small_window();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/refwin_reader.md
REFWIN_READER -- requirements
Module: refwin_reader

Interface
REQ-001 W_SIZE, default 8, window edge in pixels; the window holds W_SIZE*W_SIZE samples.
REQ-002 DATA_W, default 8, pixel width in bits.
REQ-003 pclk  in  1  pixel clock; all logic is on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 win_wr  in  1  write strobe from the window-write FSM; one accepted pixel per high cycle.
REQ-006 wr_bank  out  1  bank currently being filled by the writer; drives the buffer write-address MSB.
REQ-007 rd_addr  out  $clog2(2*W_SIZE*W_SIZE)  buffer read address: {read bank, sample index}.
REQ-008 rd_en  out  1  buffer read enable.
REQ-009 rd_data  in  DATA_W  buffer read data, valid exactly 1 cycle after rd_en.
REQ-010 pix_out  out  DATA_W  window sample, raster order within the window.
REQ-011 pix_valid  out  1  pix_out is valid.
REQ-012 pix_ready  in  1  downstream accepts the sample when pix_valid and pix_ready are both high.
REQ-013 pix_last  out  1  marks the final sample (index W_SIZE*W_SIZE-1) of the window.
REQ-014 win_done  out  1  one-cycle pulse on the cycle after pix_last is accepted.
REQ-015 overrun  out  1  sticky error flag (see REQ-027).

Function
REQ-016 Write counter counts win_wr pulses 0..W_SIZE*W_SIZE-1.
- On the pulse that reaches the terminal count, the counter wraps to 0, wr_bank toggles, and the filled bank is marked full.
REQ-017 Each bank has a full flag.
- Set per REQ-016.
- Cleared on the cycle win_done pulses for that bank.
REQ-018 FSM has states IDLE, READ and DRAIN.
REQ-019 IDLE -> READ when the bank opposite wr_bank is full; the read bank is latched and the read index is set to 0.
REQ-020 In READ:
- rd_en is high when the 2-entry output skid buffer has room for the sample in flight.
- The read index increments on every rd_en.
- After issuing index W_SIZE*W_SIZE-1 the FSM goes to DRAIN.
REQ-021 DRAIN -> IDLE when the skid buffer is empty and the last sample has been accepted; win_done pulses on that transition cycle.
REQ-022 rd_data is captured into the skid buffer 1 cycle after rd_en.
- The buffer never overflows.
- No sample is dropped or duplicated under any pix_ready pattern.
REQ-023 pix_out and pix_last are stable while pix_valid is high and pix_ready is low.
REQ-024 pix_last is high only with the sample whose index is W_SIZE*W_SIZE-1.
REQ-025 Throughput is 1 sample per cycle when pix_ready is held high.
- Latency from IDLE->READ to the first pix_valid is 2 cycles.
REQ-026 Simultaneous events:
- win_wr completing a bank in the same cycle as win_done: both take effect. The full flag of the completed bank sets; the full flag of the read bank clears.
- If both banks are full when a read completes, the FSM returns to IDLE and re-enters READ on the next cycle.
REQ-027 Overrun: if a bank completes while the other bank is still full (reader has not finished it), overrun is set.
- The wr_bank toggle still occurs.
- The write data overwrites nothing in the bank being read.
- The writer's next fill goes to the bank being read; data integrity of that bank is then undefined until overrun is cleared by reset.

Reset
REQ-028 On rst, all of the following take effect on the next pclk edge, regardless of state (including mid-window):
- State = IDLE; write counter and read index = 0; wr_bank = 0.
- Both full flags = 0; skid buffer empty.
- pix_valid = 0, pix_last = 0, win_done = 0, rd_en = 0, overrun = 0.
- rd_addr = 0, pix_out = 0.
REQ-029 Any rd_data returning in the cycle after reset is discarded.

Configuration
REQ-030 Macro REFWIN_RD_OVERRUN_EN.
- Defined: overrun detection per REQ-027 is present.
- Undefined: overrun is tied to 0, its logic is removed, and all other behaviour is unchanged.

Structure
REQ-031 A shared package refwin_pkg holds:
- Defaults for W_SIZE and DATA_W.
- The FSM state enum type.
- The constant WIN_PIX = W_SIZE*W_SIZE.
REQ-032 The 2-entry skid buffer is a sub-module named refwin_skid, parameterised by the payload width (DATA_W+1, carrying pix_last).

Verification
REQ-033 64 win_wr pulses with pix_ready held 1 -> wr_bank goes 0->1; the first pix_valid appears 2 cycles after READ entry; 64 consecutive samples are read from addresses 0..63; pix_last is on the 64th; win_done pulses once.
REQ-034 Random pix_ready at 30% duty -> all 64 samples are delivered in order with no loss or duplication, and pix_out is stable during stalls.
REQ-035 A second 64-pulse fill completes while reading bank 0, with pix_ready low -> overrun = 1 (macro defined) or 0 (undefined); wr_bank returns to 0.
REQ-036 The 64th write pulse lands in the same cycle as win_done -> the new bank is marked full, the FSM re-enters READ on the following cycle, and rd_addr starts at the opposite bank base (64 or 0).
REQ-037 rst asserted at sample 30 of a read -> on the next cycle pix_valid = 0, state = IDLE, wr_bank = 0, and no further rd_en until 64 new writes arrive.
REQ-038 W_SIZE=4 build -> 16 samples per window; pix_last on index 15; rd_addr width = 5.
